// File: rtl/alu_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : alu_seq_pkg
// Purpose  : State encoding and operand-mode constants for alu_op_sequencer.
// Revision : 1.0  initial release
// ============================================================================
package alu_seq_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        A_DRV = 3'd1,
        A_LAT = 3'd2,
        B_DRV = 3'd3,
        B_LAT = 3'd4,
        EX    = 3'd5,
        WB    = 3'd6,
        DONE  = 3'd7
    } seq_state_t;

    localparam logic MODE_REG = 1'b0;
    localparam logic MODE_IMM = 1'b1;

endpackage
`default_nettype wire

// File: rtl/tri_state_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tri_state_buffer
// Purpose  : Parametrised bus driver; releases the bus (Z) when not enabled.
// Revision : 1.0  initial release
// ============================================================================
module tri_state_buffer #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_enable,
    output tri   [WIDTH-1:0] o_data
);

    assign o_data = i_enable ? i_data : {WIDTH{1'bz}};

endmodule
`default_nettype wire

// File: rtl/alu_op_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : alu_op_sequencer
// Purpose  : Sequences one ALU instruction (reg-reg or reg-imm) over the shared
//            bus. Build option ALU_SEQ_SIGN_EXT_EN sign-extends the immediate.
// Revision : 1.0  initial release
// ============================================================================
module alu_op_sequencer
    import alu_seq_pkg::*;
#(
    parameter int               DATA_W     = 16,
    parameter int               ADDR_W     = 6,
    parameter int               IMM_W      = 6,
    parameter int               OPC_W      = 4,
    parameter logic [OPC_W-1:0] CMP_OPCODE = {OPC_W{1'b1}}
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic              mode,
    input  logic [OPC_W-1:0]  opcode,
    input  logic [ADDR_W-1:0] dest_addr,
    input  logic [ADDR_W-1:0] src_a_addr,
    input  logic [ADDR_W-1:0] src_b_addr,
    input  logic [IMM_W-1:0]  immediate,
    output tri   [DATA_W-1:0] bus_out,
    output logic              busy,
    output logic              bus_register_out_en,
    output logic              bus_register_input_en,
    output logic [ADDR_W-1:0] register_addr,
    output logic              latched_bus1_en,
    output logic              latched_bus2_en,
    output logic              alu_bus_out_en,
    output logic [OPC_W-1:0]  alu_control,
    output logic              done
);

    seq_state_t        r_state;
    seq_state_t        w_next;

    logic              r_mode;
    logic [OPC_W-1:0]  r_opcode;
    logic [ADDR_W-1:0] r_dest;
    logic [ADDR_W-1:0] r_src_a;
    logic [ADDR_W-1:0] r_src_b;
    logic [IMM_W-1:0]  r_immediate;

    logic              r_busy;
    logic              r_reg_out_en;
    logic              r_reg_in_en;
    logic [ADDR_W-1:0] r_register_addr;
    logic              r_lat1_en;
    logic              r_lat2_en;
    logic              r_alu_out_en;
    logic [OPC_W-1:0]  r_alu_control;
    logic              r_done;
    logic              r_imm_drive;

    logic [DATA_W-1:0] w_imm_ext;

    generate
        if (IMM_W == DATA_W) begin : g_imm_pass
            assign w_imm_ext = r_immediate;
        end else begin : g_imm_ext
`ifdef ALU_SEQ_SIGN_EXT_EN
            assign w_imm_ext = {{(DATA_W-IMM_W){r_immediate[IMM_W-1]}}, r_immediate};
`else
            assign w_imm_ext = {{(DATA_W-IMM_W){1'b0}}, r_immediate};
`endif
        end
    endgenerate

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (start) w_next = A_DRV;
            A_DRV:   w_next = A_LAT;
            A_LAT:   w_next = B_DRV;
            B_DRV:   w_next = B_LAT;
            B_LAT:   w_next = EX;
            EX:      w_next = (r_opcode == CMP_OPCODE) ? DONE : WB;
            WB:      w_next = DONE;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they line up with the state they belong to.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state         <= IDLE;
            r_mode          <= MODE_REG;
            r_opcode        <= '0;
            r_dest          <= '0;
            r_src_a         <= '0;
            r_src_b         <= '0;
            r_immediate     <= '0;
            r_busy          <= 1'b0;
            r_reg_out_en    <= 1'b0;
            r_reg_in_en     <= 1'b0;
            r_register_addr <= '0;
            r_lat1_en       <= 1'b0;
            r_lat2_en       <= 1'b0;
            r_alu_out_en    <= 1'b0;
            r_alu_control   <= '0;
            r_done          <= 1'b0;
            r_imm_drive     <= 1'b0;
        end else begin
            r_state <= w_next;
            if (r_state == IDLE && start) begin
                r_mode      <= mode;
                r_opcode    <= opcode;
                r_dest      <= dest_addr;
                r_src_a     <= src_a_addr;
                r_src_b     <= src_b_addr;
                r_immediate <= immediate;
            end

            r_busy          <= (w_next != IDLE);
            r_reg_out_en    <= 1'b0;
            r_reg_in_en     <= 1'b0;
            r_register_addr <= '0;
            r_lat1_en       <= 1'b0;
            r_lat2_en       <= 1'b0;
            r_alu_out_en    <= 1'b0;
            r_done          <= 1'b0;
            r_imm_drive     <= 1'b0;

            case (w_next)
                A_DRV: begin
                    // Operand registers load on this same edge, so take the address straight from the port.
                    r_reg_out_en    <= 1'b1;
                    r_register_addr <= src_a_addr;
                end
                A_LAT: begin
                    r_reg_out_en    <= 1'b1;
                    r_register_addr <= r_src_a;
                    r_lat1_en       <= 1'b1;
                    r_alu_control   <= r_opcode;
                end
                B_DRV, B_LAT: begin
                    r_lat2_en <= (w_next == B_LAT);
                    if (r_mode == MODE_REG) begin
                        r_reg_out_en    <= 1'b1;
                        r_register_addr <= r_src_b;
                    end else begin
                        r_imm_drive     <= (r_mode == MODE_IMM);
                    end
                end
                EX, WB: begin
                    r_alu_out_en    <= 1'b1;
                    r_register_addr <= r_dest;
                    r_reg_in_en     <= (w_next == WB);
                end
                DONE:    r_done <= 1'b1;
                default: ;
            endcase
        end
    end

    tri_state_buffer #(
        .WIDTH (DATA_W)
    ) u_imm_driver (
        .i_data   (w_imm_ext),
        .i_enable (r_imm_drive),
        .o_data   (bus_out)
    );

    assign busy                  = r_busy;
    assign bus_register_out_en   = r_reg_out_en;
    assign bus_register_input_en = r_reg_in_en;
    assign register_addr         = r_register_addr;
    assign latched_bus1_en       = r_lat1_en;
    assign latched_bus2_en       = r_lat2_en;
    assign alu_bus_out_en        = r_alu_out_en;
    assign alu_control           = r_alu_control;
    assign done                  = r_done;

endmodule
`default_nettype wire

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
- Parametrised successor to the single-mode immediate ALU FSM.
- Sequences one ALU instruction over the shared tri-state data bus in either of two modes:
  - register-register: dest = A op B
  - register-immediate: dest = A op imm
- Drives register-file read/write enables, the ALU operand latches, ALU output enable and the immediate bus driver.
- Optionally suppresses write-back for compare-class opcodes.
- Sits between the instruction decoder (start/done) and the register file / ALU on the common bus.

Parameters:
- DATA_W, 16, bus and register data width.
- ADDR_W, 6, register address width.
- IMM_W, 6, immediate field width; must satisfy IMM_W <= DATA_W.
- OPC_W, 4, opcode / alu_control width.
- CMP_OPCODE, 4'b1111 (OPC_W bits), opcode whose result is computed but not written back.

Ports:
- clock  input  1  system clock
- reset  input  1  synchronous, active-high
- start  input  1  instruction request; sampled only in IDLE
- mode  input  1  0 = register-register, 1 = register-immediate
- opcode  input  OPC_W  ALU operation
- dest_addr  input  ADDR_W  destination register
- src_a_addr  input  ADDR_W  operand A register
- src_b_addr  input  ADDR_W  operand B register (mode 0)
- immediate  input  IMM_W  operand B value (mode 1)
- bus_out  output(tri)  DATA_W  extended immediate onto shared bus; Z when not driving
- busy  output  1  high whenever state != IDLE
- bus_register_out_en  output  1  register file drives bus
- bus_register_input_en  output  1  register file captures bus
- register_addr  output  ADDR_W  register file address
- latched_bus1_en  output  1  ALU operand A latch strobe
- latched_bus2_en  output  1  ALU operand B latch strobe
- alu_bus_out_en  output  1  ALU drives bus
- alu_control  output  OPC_W  ALU operation select
- done  output  1  one-cycle completion pulse

Behaviour:

Reset, clocking and clock-domain rules:
- Clock is clock. Reset is reset: synchronous, active-high.
- On reset, state = IDLE and all outputs are 0 (register_addr = 0, alu_control = 0), with bus_out = Z.
- Reset mid-instruction aborts at the next edge: no write-back and no done.

Start acceptance and capture:
- Start is accepted only when state = IDLE and start = 1.
- On acceptance, mode, opcode, all addresses and the immediate are captured into internal registers. Later input changes have no effect.
- start while busy is ignored; it is not queued.

States and outputs:
- Outputs are registered Moore decodes of the next state, so they are valid in the cycle the state is current.
- IDLE: all enables 0.
- A_DRV: register_addr = src_a, bus_register_out_en = 1.
- A_LAT: as A_DRV, plus latched_bus1_en = 1. alu_control is loaded with the captured opcode and held until the next accepted start.
- B_DRV:
  - mode 0: register_addr = src_b, bus_register_out_en = 1.
  - mode 1: bus_out = extended immediate, bus_register_out_en = 0.
- B_LAT: as B_DRV, plus latched_bus2_en = 1.
- EX: alu_bus_out_en = 1, register_addr = dest.
- WB: as EX, plus bus_register_input_en = 1.
- DONE: done = 1, all other enables 0.

Transitions:
- IDLE -> A_DRV (on accepted start) -> A_LAT -> B_DRV -> B_LAT -> EX.
- EX -> WB -> DONE, unless captured opcode == CMP_OPCODE, in which case EX -> DONE.
- DONE -> IDLE.
- Latency: done is high 7 cycles after the start-sampling edge (6 for CMP_OPCODE). busy is 0 in the cycle after DONE.
- Back-to-back: start held high re-accepts in the IDLE cycle following DONE, giving an 8-cycle throughput.

Bus contention rule:
- bus_out, bus_register_out_en and alu_bus_out_en are mutually exclusive in every state.
- The bench asserts this as an invariant.

Immediate extension:
- Immediate is extended to DATA_W using zero-fill by default.
- IMM_W == DATA_W passes the immediate through unchanged.

Optional Feature:
- Macro ALU_SEQ_SIGN_EXT_EN.
- Defined: immediate is sign-extended from bit IMM_W-1.
- Undefined: immediate is zero-extended.
- No other behaviour changes.

Decomposition:
- Package alu_seq_pkg holds:
  - state encoding constants: IDLE, A_DRV, A_LAT, B_DRV, B_LAT, EX, WB, DONE (3-bit);
  - MODE_REG = 1'b0, MODE_IMM = 1'b1.
- Sub-module: the existing tri_state_buffer, instantiated at DATA_W for bus_out.
- Immediate extension stays inline.

Test Plan:
- Reset, then mode = 1, opcode = 4'h2, src_a = dest = 6'd5, immediate = 6'h2A, start pulse -> bus_out = 16'h002A with latched_bus2_en in B_LAT; WB asserts register_addr = 5; done in cycle 7.
- mode = 0, src_a = 3, src_b = 9, dest = 12 -> register_addr sequence 3, 3, 9, 9, 12, 12; bus_out Z throughout; done once.
- opcode = CMP_OPCODE -> bus_register_input_en never asserted; done 6 cycles after start.
- immediate = 6'h3F -> bus_out = 16'h003F without the macro, 16'hFFFF with ALU_SEQ_SIGN_EXT_EN.
- start re-pulsed during A_LAT, and src_a changed mid-op -> ignored; the original operands complete; exactly one done.
- reset asserted in B_LAT -> next cycle all outputs 0, bus_out Z, no done; a fresh start then completes normally.
